// File: rtl/lsw_data_alloc_if.sv
// Store-data slot allocation bus: dispatch requests and grants, buffer clear
// strobes, head reclaim, flush rewind and allocator status.
interface lsw_data_alloc_if #(
  parameter int ADDR_WIDTH = 8
);
  logic [1:0]            alloc_req;
  logic                  alloc_gnt;
  logic [ADDR_WIDTH-1:0] alloc_addr0;
  logic [ADDR_WIDTH-1:0] alloc_addr1;
  logic [ADDR_WIDTH-1:0] alloc_addr2;
  logic [ADDR_WIDTH-1:0] new0_addr;
  logic [ADDR_WIDTH-1:0] new1_addr;
  logic [ADDR_WIDTH-1:0] new2_addr;
  logic                  new0_en;
  logic                  new1_en;
  logic                  new2_en;
  logic                  new0_odd;
  logic                  new1_odd;
  logic                  new2_odd;
  logic [1:0]            free_cnt;
  logic                  flush;
  logic [ADDR_WIDTH-1:0] flush_addr;
  logic                  ready;
  logic [ADDR_WIDTH-1:0] count;
  logic                  full;
  logic                  free_err;

  // Requester side: dispatch stage plus drain/flush sources.
  modport master (
    output alloc_req, free_cnt, flush, flush_addr,
    input  alloc_gnt, alloc_addr0, alloc_addr1, alloc_addr2,
    input  new0_addr, new1_addr, new2_addr,
    input  new0_en, new1_en, new2_en,
    input  new0_odd, new1_odd, new2_odd,
    input  ready, count, full, free_err
  );

  // Allocator side.
  modport slave (
    input  alloc_req, free_cnt, flush, flush_addr,
    output alloc_gnt, alloc_addr0, alloc_addr1, alloc_addr2,
    output new0_addr, new1_addr, new2_addr,
    output new0_en, new1_en, new2_en,
    output new0_odd, new1_odd, new2_odd,
    output ready, count, full, free_err
  );
endinterface

// File: rtl/lsw_data_alloc.sv
// Allocation / reclaim controller for the banked store-data buffer.
// Hands out up to three consecutive slots per cycle (all-or-nothing), reclaims
// in FIFO order, waits out the buffer init sweep and rewinds on flush.
module lsw_data_alloc #(
  parameter int ENTRIES     = 240,
  parameter int ADDR_WIDTH  = 8,
  parameter int INIT_CYCLES = 128
) (
  input  logic            clk,
  input  logic            rst,
  lsw_data_alloc_if.slave bus
);

  localparam int INIT_CW = $clog2(INIT_CYCLES) + 1;
  localparam logic [ADDR_WIDTH:0]   ENT_W     = (ADDR_WIDTH+1)'(ENTRIES);
  localparam logic [ADDR_WIDTH-1:0] ENT_A     = ADDR_WIDTH'(ENTRIES);
  localparam logic [ADDR_WIDTH-1:0] FULL_LIM  = ADDR_WIDTH'(ENTRIES - 3);
  localparam logic [INIT_CW-1:0]    INIT_LAST = INIT_CW'(INIT_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Slot index advance with wrap from ENTRIES-1 to 0 (inc is at most 3).
  function automatic logic [ADDR_WIDTH-1:0] wrap_add(
    input logic [ADDR_WIDTH-1:0] base,
    input logic [1:0]            inc
  );
    logic [ADDR_WIDTH:0] sum;
    sum = {1'b0, base} + {{(ADDR_WIDTH-1){1'b0}}, inc};
    if (sum >= ENT_W) begin
      sum = sum - ENT_W;
    end else begin
      sum = sum;
    end
    return sum[ADDR_WIDTH-1:0];
  endfunction

  state_t                state_q, state_d;
  logic [INIT_CW-1:0]    init_cnt_q, init_cnt_d;
  logic                  ready_q, ready_d;
  logic [ADDR_WIDTH-1:0] alloc_ptr_q, alloc_ptr_d;
  logic [ADDR_WIDTH-1:0] free_ptr_q, free_ptr_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;
  logic                  full_q, full_d;
  logic                  free_err_q, free_err_d;
  logic [2:0]            new_en_q, new_en_d;
  logic [2:0]            new_odd_q, new_odd_d;
  logic [ADDR_WIDTH-1:0] new_addr_q [3];
  logic [ADDR_WIDTH-1:0] new_addr_d [3];

  logic                  gnt_s;
  logic                  free_ok_s;
  logic [ADDR_WIDTH-1:0] alloc_addr_s [3];
  logic [ADDR_WIDTH-1:0] req_ext_s;
  logic [ADDR_WIDTH-1:0] free_ext_s;
  logic [ADDR_WIDTH-1:0] flush_dist_s;

  // Init sweep sequencing: count INIT_CYCLES cycles, then open allocation for good.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    ready_d    = ready_q;
    case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + {{(INIT_CW-1){1'b0}}, 1'b1};
        if (init_cnt_q == INIT_LAST) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end else begin
          state_d = ST_INIT;
          ready_d = 1'b0;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
        ready_d = 1'b1;
      end
      default: begin
        state_d = ST_INIT;
        ready_d = 1'b0;
      end
    endcase
  end

  // Grant decision and candidate slot addresses; the grant sees count before this cycle's free.
  always_comb begin
    req_ext_s  = {{(ADDR_WIDTH-2){1'b0}}, bus.alloc_req};
    free_ext_s = {{(ADDR_WIDTH-2){1'b0}}, bus.free_cnt};
    for (int k = 0; k < 3; k++) begin
      alloc_addr_s[k] = wrap_add(alloc_ptr_q, 2'(k));
    end
    gnt_s = ready_q & (state_q == ST_RUN) & ~bus.flush & (bus.alloc_req != 2'd0)
          & (({1'b0, count_q} + {1'b0, req_ext_s}) <= ENT_W);
    free_ok_s = (free_ext_s <= count_q);
  end

  // Pointer, occupancy and error bookkeeping including flush rewind.
  always_comb begin
    free_err_d = free_err_q | ~free_ok_s;
    if (free_ok_s) begin
      free_ptr_d = wrap_add(free_ptr_q, bus.free_cnt);
    end else begin
      free_ptr_d = free_ptr_q;
    end
    // Distance from the new head to the rewound tail, modulo ENTRIES.
    if (bus.flush_addr >= free_ptr_d) begin
      flush_dist_s = bus.flush_addr - free_ptr_d;
    end else begin
      flush_dist_s = bus.flush_addr - free_ptr_d + ENT_A;
    end
    if (bus.flush) begin
      alloc_ptr_d = bus.flush_addr;
      count_d     = flush_dist_s;
    end else begin
      if (gnt_s) begin
        alloc_ptr_d = wrap_add(alloc_ptr_q, bus.alloc_req);
      end else begin
        alloc_ptr_d = alloc_ptr_q;
      end
      count_d = count_q
              + (gnt_s ? req_ext_s : {ADDR_WIDTH{1'b0}})
              - (free_ok_s ? free_ext_s : {ADDR_WIDTH{1'b0}});
    end
    full_d = (count_d > FULL_LIM);
  end

  // Buffer clear strobes for the slots granted this cycle; idle slots stay disabled.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      if (gnt_s && (2'(k) < bus.alloc_req)) begin
        new_en_d[k]   = 1'b1;
        new_addr_d[k] = alloc_addr_s[k];
        new_odd_d[k]  = alloc_addr_s[k][0];
      end else begin
        new_en_d[k]   = 1'b0;
        new_addr_d[k] = {ADDR_WIDTH{1'b0}};
        new_odd_d[k]  = 1'b0;
      end
    end
  end

  // State register with synchronous reset back to the init sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= {INIT_CW{1'b0}};
      ready_q     <= 1'b0;
      alloc_ptr_q <= {ADDR_WIDTH{1'b0}};
      free_ptr_q  <= {ADDR_WIDTH{1'b0}};
      count_q     <= {ADDR_WIDTH{1'b0}};
      full_q      <= 1'b0;
      free_err_q  <= 1'b0;
      new_en_q    <= 3'b000;
      new_odd_q   <= 3'b000;
      for (int k = 0; k < 3; k++) begin
        new_addr_q[k] <= {ADDR_WIDTH{1'b0}};
      end
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      ready_q     <= ready_d;
      alloc_ptr_q <= alloc_ptr_d;
      free_ptr_q  <= free_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      free_err_q  <= free_err_d;
      new_en_q    <= new_en_d;
      new_odd_q   <= new_odd_d;
      for (int k = 0; k < 3; k++) begin
        new_addr_q[k] <= new_addr_d[k];
      end
    end
  end

  assign bus.alloc_gnt   = gnt_s;
  assign bus.alloc_addr0 = alloc_addr_s[0];
  assign bus.alloc_addr1 = alloc_addr_s[1];
  assign bus.alloc_addr2 = alloc_addr_s[2];
  assign bus.new0_en     = new_en_q[0];
  assign bus.new1_en     = new_en_q[1];
  assign bus.new2_en     = new_en_q[2];
  assign bus.new0_addr   = new_addr_q[0];
  assign bus.new1_addr   = new_addr_q[1];
  assign bus.new2_addr   = new_addr_q[2];
  assign bus.new0_odd    = new_odd_q[0];
  assign bus.new1_odd    = new_odd_q[1];
  assign bus.new2_odd    = new_odd_q[2];
  assign bus.ready       = ready_q;
  assign bus.count       = count_q;
  assign bus.full        = full_q;
  assign bus.free_err    = free_err_q;

endmodule

// File: tb/tb_lsw_data_alloc.sv
// Bench for lsw_data_alloc: directed scenarios with literal expectations plus
// a queue-free occupancy model compared on every negative clock edge.
module tb_lsw_data_alloc;
  localparam int ENT = 240;
  localparam int ICY = 128;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  lsw_data_alloc_if #(.ADDR_WIDTH(8)) bus ();

  lsw_data_alloc #(.ENTRIES(ENT), .ADDR_WIDTH(8), .INIT_CYCLES(ICY)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [2:0] dut_en  = {bus.new2_en, bus.new1_en, bus.new0_en};
  wire [2:0] dut_odd = {bus.new2_odd, bus.new1_odd, bus.new0_odd};
  wire [7:0] dut_naddr [3];
  wire [7:0] dut_aaddr [3];
  assign dut_naddr[0] = bus.new0_addr;
  assign dut_naddr[1] = bus.new1_addr;
  assign dut_naddr[2] = bus.new2_addr;
  assign dut_aaddr[0] = bus.alloc_addr0;
  assign dut_aaddr[1] = bus.alloc_addr1;
  assign dut_aaddr[2] = bus.alloc_addr2;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state: cycles since reset, ring pointers, occupancy, sticky error, pending strobes.
  bit m_valid;
  int m_cyc, m_aptr, m_fptr, m_count;
  bit m_err;
  bit m_en [3];
  int m_addr [3];
  int n_cyc, n_aptr, n_fptr, n_count;
  bit n_err;
  bit n_en [3];
  int n_addr [3];

  // Compare DUT against the model and work out the model's next state from this cycle's inputs.
  always @(negedge clk) begin
    if (m_valid) begin
      bit eg, fok;
      int req, fr, fa, nf;
      req = int'(bus.alloc_req);
      fr  = int'(bus.free_cnt);
      fa  = int'(bus.flush_addr);
      eg  = (m_cyc >= ICY) && !bus.flush && (req != 0) && (m_count + req <= ENT);
      chk("m_gnt", bus.alloc_gnt, eg);
      if (eg) begin
        for (int k = 0; k < 3; k++) chk($sformatf("m_alloc_addr%0d", k), dut_aaddr[k], (m_aptr + k) % ENT);
      end
      chk("m_ready", bus.ready, (m_cyc >= ICY));
      chk("m_count", bus.count, m_count);
      chk("m_full", bus.full, (m_count > ENT - 3));
      chk("m_free_err", bus.free_err, m_err);
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("m_new%0d_en", k), dut_en[k], m_en[k]);
        if (m_en[k]) begin
          chk($sformatf("m_new%0d_addr", k), dut_naddr[k], m_addr[k]);
          chk($sformatf("m_new%0d_odd", k), dut_odd[k], m_addr[k] % 2);
        end
      end
      fok = (fr <= m_count);
      nf  = fok ? (m_fptr + fr) % ENT : m_fptr;
      n_fptr  <= nf;
      n_err   <= m_err || !fok;
      n_cyc   <= (m_cyc < ICY) ? m_cyc + 1 : m_cyc;
      if (bus.flush) begin
        n_aptr  <= fa;
        n_count <= (fa - nf + ENT) % ENT;
      end else begin
        n_aptr  <= eg ? (m_aptr + req) % ENT : m_aptr;
        n_count <= m_count + (eg ? req : 0) - (fok ? fr : 0);
      end
      for (int k = 0; k < 3; k++) begin
        n_en[k]   <= eg && (k < req);
        n_addr[k] <= (m_aptr + k) % ENT;
      end
    end
  end

  // Commit the model at each clock edge, or clear it on reset.
  always @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b1;
      m_cyc <= 0; m_aptr <= 0; m_fptr <= 0; m_count <= 0; m_err <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        m_en[k] <= 1'b0;
        m_addr[k] <= 0;
      end
    end else if (m_valid) begin
      m_cyc <= n_cyc; m_aptr <= n_aptr; m_fptr <= n_fptr; m_count <= n_count; m_err <= n_err;
      for (int k = 0; k < 3; k++) begin
        m_en[k] <= n_en[k];
        m_addr[k] <= n_addr[k];
      end
    end
  end

  task automatic drive(input logic [1:0] r, input logic [1:0] f, input logic fl, input logic [7:0] fa);
    bus.alloc_req  = r;
    bus.free_cnt   = f;
    bus.flush      = fl;
    bus.flush_addr = fa;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic [1:0] r, input logic [1:0] f);
    drive(r, f, 1'b0, 8'd0);
    tick();
  endtask

  // Hold alloc_req=3 through the sweep: no grant until cycle 128, then slots 0,1,2.
  task automatic holdoff(input string tag);
    drive(2'd3, 2'd0, 1'b0, 8'd0);
    for (int i = 0; i < ICY; i++) begin
      #1;
      if (i == 0 || i == ICY - 1) chk({tag, "_gnt_blocked"}, bus.alloc_gnt, 1'b0);
      tick();
    end
    #1;
    chk({tag, "_gnt128"}, bus.alloc_gnt, 1'b1);
    chk({tag, "_addr0"}, bus.alloc_addr0, 8'd0);
    chk({tag, "_addr1"}, bus.alloc_addr1, 8'd1);
    chk({tag, "_addr2"}, bus.alloc_addr2, 8'd2);
    tick();
    drive(2'd0, 2'd0, 1'b0, 8'd0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    m_valid = 1'b0;
    rst = 1'b1;
    drive(2'd0, 2'd0, 1'b0, 8'd0);
    tick();
    tick();
    rst = 1'b0;
    chk("rst_ready", bus.ready, 1'b0);
    chk("rst_count", bus.count, 8'd0);
    chk("rst_free_err", bus.free_err, 1'b0);
    chk("rst_new_en", dut_en, 3'b000);

    // Init hold-off and first grant strobes.
    holdoff("init");
    chk("init_new_en", dut_en, 3'b111);
    chk("init_new0_addr", bus.new0_addr, 8'd0);
    chk("init_new1_addr", bus.new1_addr, 8'd1);
    chk("init_new2_addr", bus.new2_addr, 8'd2);
    chk("init_new_odd", dut_odd, 3'b010);
    chk("init_count", bus.count, 8'd3);

    // Wrap: advance alloc_ptr to 238 with balanced grants and frees.
    cyc(2'd1, 2'd0);
    for (int i = 0; i < 78; i++) cyc(2'd3, 2'd3);
    drive(2'd3, 2'd0, 1'b0, 8'd0);
    #1;
    chk("wrap_gnt", bus.alloc_gnt, 1'b1);
    chk("wrap_addr0", bus.alloc_addr0, 8'd238);
    chk("wrap_addr1", bus.alloc_addr1, 8'd239);
    chk("wrap_addr2", bus.alloc_addr2, 8'd0);
    tick();
    chk("wrap_new_odd", dut_odd, 3'b010);
    chk("wrap_new2_addr", bus.new2_addr, 8'd0);
    chk("wrap_count", bus.count, 8'd7);
    drive(2'd1, 2'd0, 1'b0, 8'd0);
    #1;
    chk("wrap_ptr1", bus.alloc_addr0, 8'd1);
    tick();
    cyc(2'd0, 2'd3);
    cyc(2'd0, 2'd3);
    cyc(2'd0, 2'd2);
    chk("drain_count", bus.count, 8'd0);

    // Full: 240 slots, denial with and without a same-cycle free, then 2 fits and 3 does not.
    for (int i = 0; i < 80; i++) cyc(2'd3, 2'd0);
    chk("full_count", bus.count, 8'd240);
    chk("full_flag", bus.full, 1'b1);
    drive(2'd1, 2'd0, 1'b0, 8'd0);
    #1;
    chk("full_deny1", bus.alloc_gnt, 1'b0);
    tick();
    drive(2'd1, 2'd2, 1'b0, 8'd0);
    #1;
    chk("full_deny_with_free", bus.alloc_gnt, 1'b0);
    tick();
    chk("full_after_free", bus.count, 8'd238);
    chk("full_flag_238", bus.full, 1'b1);
    drive(2'd3, 2'd0, 1'b0, 8'd0);
    #1;
    chk("full_deny3", bus.alloc_gnt, 1'b0);
    drive(2'd2, 2'd0, 1'b0, 8'd0);
    #1;
    chk("full_grant2", bus.alloc_gnt, 1'b1);
    tick();
    chk("full_count_again", bus.count, 8'd240);

    // Simultaneous allocate and free from count 10.
    for (int i = 0; i < 76; i++) cyc(2'd0, 2'd3);
    cyc(2'd0, 2'd2);
    chk("sim_count10", bus.count, 8'd10);
    chk("sim_not_full", bus.full, 1'b0);
    cyc(2'd3, 2'd2);
    chk("sim_count11", bus.count, 8'd11);

    // Underflow: free 2 with count 1 is ignored and sets the sticky error.
    cyc(2'd0, 2'd3);
    cyc(2'd0, 2'd3);
    cyc(2'd0, 2'd3);
    cyc(2'd0, 2'd1);
    chk("uf_count1", bus.count, 8'd1);
    cyc(2'd0, 2'd2);
    chk("uf_err", bus.free_err, 1'b1);
    chk("uf_count_kept", bus.count, 8'd1);
    cyc(2'd0, 2'd0);
    chk("uf_err_sticky", bus.free_err, 1'b1);

    // Mid-run reset restarts the sweep.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rr_free_err", bus.free_err, 1'b0);
    chk("rr_count", bus.count, 8'd0);
    chk("rr_ready", bus.ready, 1'b0);
    holdoff("rr");

    // Flush: free_ptr=5, alloc_ptr=20, rewind to 9 with a same-cycle free of 1.
    for (int i = 0; i < 5; i++) cyc(2'd3, 2'd0);
    cyc(2'd0, 2'd3);
    cyc(2'd2, 2'd2);
    chk("fl_pre_count", bus.count, 8'd15);
    drive(2'd3, 2'd1, 1'b1, 8'd9);
    #1;
    chk("fl_gnt_blocked", bus.alloc_gnt, 1'b0);
    chk("fl_new_en_issue", dut_en, 3'b011);
    chk("fl_new0_addr", bus.new0_addr, 8'd18);
    tick();
    chk("fl_count", bus.count, 8'd3);
    drive(2'd1, 2'd0, 1'b0, 8'd0);
    #1;
    chk("fl_ptr9", bus.alloc_addr0, 8'd9);
    tick();
    chk("fl_count4", bus.count, 8'd4);
    cyc(2'd0, 2'd0);
    cyc(2'd0, 2'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lsw_data_alloc.md
# lsw_data_alloc

Allocation and reclaim controller for the banked store-data buffer (`lsw_data`: 240 entries, 8-bit slot address, bit 0 selects the even/odd bank). It hands out up to three consecutive store-data slots per cycle to the store-dispatch stage and drives the buffer's `new0..new2` clear ports. It reclaims slots in FIFO order as stores drain. It also holds off allocation until the buffer's post-reset 128-cycle init sweep has completed, and rewinds the allocation pointer on pipeline flush.

## Interface
Parameters:
- ENTRIES, 240: slot count. Must be even.
- ADDR_WIDTH, 8: slot address width.
- INIT_CYCLES, 128: cycles of the buffer init sweep after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Synchronous, active-high; acts only on the rising edge of clk while high.
- alloc_req  in  2  number of slots requested this cycle (0-3).
- alloc_gnt  out  1  request granted in full this cycle. Combinational.
- alloc_addr0..2  out  ADDR_WIDTH each  slots assigned to requests 0..2. Combinational, valid when alloc_gnt.
- new0_addr, new1_addr, new2_addr  out  ADDR_WIDTH each  buffer clear addresses.
- new0_en, new1_en, new2_en  out  1 each  buffer clear enables.
- new0_odd, new1_odd, new2_odd  out  1 each  bank of the corresponding slot.
- free_cnt  in  2  slots released at the head this cycle (0-3).
- flush  in  1  discard speculative allocations.
- flush_addr  in  ADDR_WIDTH  new allocation pointer on flush; must lie in [free_ptr, alloc_ptr].
- ready  out  1  init sweep done; allocation permitted.
- count  out  ADDR_WIDTH  slots currently allocated.
- full  out  1  count > ENTRIES-3.
- free_err  out  1  sticky; set when free_cnt exceeds count.

## Operation
- **State registers.**
  - alloc_ptr: next slot to hand out.
  - free_ptr: oldest allocated slot.
  - count.
  - init counter.
  - ready.
  - free_err.
  - Registered new* outputs.
- **Reset values.** All pointers, count, init counter, new*_en, new*_addr, new*_odd, ready and free_err are 0.
- **State machine:** INIT -> RUN.
  - INIT: the init counter increments every cycle. On the cycle it equals INIT_CYCLES-1, the next state is RUN and ready becomes 1. alloc_gnt is forced to 0 in INIT.
  - RUN: terminal until the next rst.
- **Grant rule.**
  - alloc_gnt = ready & ~flush & (alloc_req != 0) & (count + alloc_req <= ENTRIES).
  - Grants are all-or-nothing; a partial grant is never issued.
  - The grant uses count before this cycle's free, which is conservative.
- **Slot addresses.**
  - alloc_addrK = (alloc_ptr + K) mod ENTRIES, with the wrap from ENTRIES-1 to 0.
  - ENTRIES is even, so the parity of consecutive slots alternates across the wrap.
  - Consequence: slot 0 and slot 2 share a bank and slot 1 takes the other bank, which is the buffer's required bank steering.
- **On grant of n slots.**
  - alloc_ptr advances by n, modulo ENTRIES.
  - Next cycle, new0..n-1 registers = {en=1, addr=alloc_addrK, odd=alloc_addrK[0]}.
  - Enables for unused slots are 0.
  - All new*_en are 0 in any cycle following a non-grant.
- **Free.** free_ptr advances by free_cnt, modulo ENTRIES.
- **Count update.** count_next = count + granted n - free_cnt.
- **Free underflow.** If free_cnt > count, the free is ignored for that cycle and free_err is set. free_err clears only on rst.
- **Flush.**
  - alloc_ptr <= flush_addr.
  - count <= (flush_addr - free_ptr_next) mod ENTRIES, where free_ptr_next includes this cycle's free.
  - A full buffer (flush_addr == free_ptr_next while count was ENTRIES) is not rewindable; flush_addr must differ from free_ptr_next, or count must have been 0.
  - Allocation is blocked in the flush cycle.
  - new*_en outputs already registered from the previous cycle still issue.
- **Reset mid-operation.** Returns the block to INIT and restarts the full 128-cycle sweep. All allocations are lost.

## Timing
- Grant and alloc_addr are the same cycle as alloc_req (combinational).
- new* strobes follow the grant by 1 cycle.
- count, full and the pointers update at the clock edge after the request, free or flush.
- After rst deasserts, ready rises at the edge following INIT_CYCLES cycles in INIT, i.e. cycle 128.
- A free and an allocation in the same cycle are both applied.
- With count=ENTRIES, a request of 1 plus a free of 1 is not granted this cycle; it is granted next cycle.

## Test plan
1. **Init hold-off.** Deassert rst; hold alloc_req=3 every cycle -> alloc_gnt=0 for cycles 0-127. Grant at cycle 128 with addrs 0,1,2. Cycle 129: new0/1/2 = 0/1/2, odd = 0/1/0.
2. **Wrap.** Set alloc_ptr to 238 via repeated grants and frees. Request 3 -> addrs 238, 239, 0 with odd = 0, 1, 0. alloc_ptr becomes 1.
3. **Full.** Allocate 240 slots total with no frees -> count=240, full=1, alloc_req=1 denied. Next cycle free_cnt=2 -> count=238. Then alloc_req=2 is granted, while alloc_req=3 in the same state is denied.
4. **Simultaneous.** count=10; alloc_req=3 and free_cnt=2 in the same cycle -> count=11, both pointers advance.
5. **Flush.** free_ptr=5, alloc_ptr=20; flush with flush_addr=9 and free_cnt=1 -> alloc_ptr=9, free_ptr=6, count=3, alloc_gnt=0 that cycle.
6. **Underflow and reset.** count=1, free_cnt=2 -> free ignored, free_err=1. Then assert rst mid-run -> free_err=0, count=0, ready=0, and the 128-cycle hold-off repeats.
